// File: rtl/rob_param.sv
// -----------------------------------------------------------------------------
// rob_param -- parameterised reorder buffer
//
// Purpose:
//   Allocates entries in program order and accepts out-of-order results from
//   FU_PORTS functional-unit completion ports. It retires at most one entry
//   per cycle, in order. A retiring entry flagged as mispredicted flushes the
//   whole buffer and redirects fetch.
//
// Parameters:
//   DEPTH      entry count (power of two, >= 4)
//   DATA_W     result width
//   REG_IDX_W  architectural register index width
//   FU_PORTS   number of completion ports
//   IDX_W      log2(DEPTH), derived
//
// Ports:
//   in_clk, in_rst              rising-edge clock, synchronous active-high reset
//   in_reg_done / in_reg_dst / in_reg_set_nzcv
//                               allocation request plus its destination and
//                               flag-write attribute
//   out_reg_next_rob_index      slot the next allocation will receive
//   out_reg_full                no free slot
//   in_fu_*                     per-port completion: valid, ROB index, value,
//                               flags, mispredict flag, redirect PC
//   out_rs_broadcast_*          registered echo of every valid completion
//   out_reg_commit_* / out_reg_index / out_reg_set_nzcv / out_reg_nzcv
//                               one-cycle commit pulse and its payload
//   out_fetch_mispredict / out_fetch_new_PC
//                               one-cycle flush pulse and its redirect target
//
// Optional feature (macro ROB_PERF_CNT_EN):
//   Adds out_perf_commits and out_perf_flushes. These are 32-bit wrapping
//   counters of commit pulses and flush pulses, cleared by reset.
// -----------------------------------------------------------------------------
module rob_param #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64,
  parameter int REG_IDX_W = 5,
  parameter int FU_PORTS  = 2,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_reg_done,
  input  logic [REG_IDX_W-1:0]         in_reg_dst,
  input  logic                         in_reg_set_nzcv,
  output logic [IDX_W-1:0]             out_reg_next_rob_index,
  output logic                         out_reg_full,
  input  logic [FU_PORTS-1:0]          in_fu_done,
  input  logic [FU_PORTS*IDX_W-1:0]    in_fu_dst_rob_index,
  input  logic [FU_PORTS*DATA_W-1:0]   in_fu_value,
  input  logic [FU_PORTS*4-1:0]        in_fu_nzcv,
  input  logic [FU_PORTS-1:0]          in_fu_is_mispred,
  input  logic [FU_PORTS*64-1:0]       in_fu_new_PC,
  output logic [FU_PORTS-1:0]          out_rs_broadcast_done,
  output logic [FU_PORTS*IDX_W-1:0]    out_rs_broadcast_index,
  output logic [FU_PORTS*DATA_W-1:0]   out_rs_broadcast_value,
  output logic [FU_PORTS*4-1:0]        out_rs_broadcast_nzcv,
  output logic                         out_reg_commit_done,
  output logic [REG_IDX_W-1:0]         out_reg_index,
  output logic [DATA_W-1:0]            out_reg_commit_value,
  output logic [IDX_W-1:0]             out_reg_commit_rob_index,
  output logic                         out_reg_set_nzcv,
  output logic [3:0]                   out_reg_nzcv,
  output logic                         out_fetch_mispredict,
  output logic [63:0]                  out_fetch_new_PC
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                  out_perf_commits,
  output logic [31:0]                  out_perf_flushes
`endif
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W:0] PTR_ONE = 1;

  // Entry storage
  logic [1:0]           r_state    [DEPTH];
  logic [REG_IDX_W-1:0] r_dst      [DEPTH];
  logic                 r_set_nzcv [DEPTH];
  logic [DATA_W-1:0]    r_value    [DEPTH];
  logic [3:0]           r_nzcv     [DEPTH];
  logic                 r_mispred  [DEPTH];
  logic [63:0]          r_new_pc   [DEPTH];

  // Pointers carry an extra wrap bit so that full and empty are distinguishable
  logic [IDX_W:0] r_head;
  logic [IDX_W:0] r_tail;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_alloc;
  logic             w_commit;
  logic             w_flush;

  // Per-entry completion select (lowest-numbered matching port)
  logic [DEPTH-1:0]  w_hit;
  logic [DATA_W-1:0] w_hit_value   [DEPTH];
  logic [3:0]        w_hit_nzcv    [DEPTH];
  logic              w_hit_mispred [DEPTH];
  logic [63:0]       w_hit_pc      [DEPTH];

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (r_head[IDX_W] != r_tail[IDX_W]) && (w_head_idx == w_tail_idx);
  assign w_alloc    = in_reg_done && !w_full;
  assign w_commit   = (r_state[w_head_idx] == ST_DONE);
  assign w_flush    = w_commit && r_mispred[w_head_idx];

  assign out_reg_full           = w_full;
  assign out_reg_next_rob_index = w_tail_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic              w_sel_hit;
    logic [DATA_W-1:0] w_sel_value;
    logic [3:0]        w_sel_nzcv;
    logic              w_sel_mispred;
    logic [63:0]       w_sel_pc;

    // Scan from the highest port down so the lowest matching port is the
    // last assignment and therefore wins a same-index collision.
    always_comb begin
      w_sel_hit     = 1'b0;
      w_sel_value   = '0;
      w_sel_nzcv    = '0;
      w_sel_mispred = 1'b0;
      w_sel_pc      = '0;
      for (int p = FU_PORTS - 1; p >= 0; p--) begin
        if (in_fu_done[p] && (in_fu_dst_rob_index[p*IDX_W +: IDX_W] == IDX_W'(gi))) begin
          w_sel_hit     = 1'b1;
          w_sel_value   = in_fu_value[p*DATA_W +: DATA_W];
          w_sel_nzcv    = in_fu_nzcv[p*4 +: 4];
          w_sel_mispred = in_fu_is_mispred[p];
          w_sel_pc      = in_fu_new_PC[p*64 +: 64];
        end
      end
    end

    assign w_hit[gi]         = w_sel_hit;
    assign w_hit_value[gi]   = w_sel_value;
    assign w_hit_nzcv[gi]    = w_sel_nzcv;
    assign w_hit_mispred[gi] = w_sel_mispred;
    assign w_hit_pc[gi]      = w_sel_pc;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_head                   <= '0;
      r_tail                   <= '0;
      out_rs_broadcast_done    <= '0;
      out_rs_broadcast_index   <= '0;
      out_rs_broadcast_value   <= '0;
      out_rs_broadcast_nzcv    <= '0;
      out_reg_commit_done      <= 1'b0;
      out_reg_index            <= '0;
      out_reg_commit_value     <= '0;
      out_reg_commit_rob_index <= '0;
      out_reg_set_nzcv         <= 1'b0;
      out_reg_nzcv             <= '0;
      out_fetch_mispredict     <= 1'b0;
      out_fetch_new_PC         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i]    <= ST_FREE;
        r_dst[i]      <= '0;
        r_set_nzcv[i] <= 1'b0;
        r_value[i]    <= '0;
        r_nzcv[i]     <= '0;
        r_mispred[i]  <= 1'b0;
        r_new_pc[i]   <= '0;
      end
    end else begin
      // Every valid completion is echoed, accepted or not
      out_rs_broadcast_done  <= in_fu_done;
      out_rs_broadcast_index <= in_fu_dst_rob_index;
      out_rs_broadcast_value <= in_fu_value;
      out_rs_broadcast_nzcv  <= in_fu_nzcv;

      out_reg_commit_done  <= w_commit;
      out_fetch_mispredict <= w_flush;

      if (w_commit) begin
        out_reg_index            <= r_dst[w_head_idx];
        out_reg_commit_value     <= r_value[w_head_idx];
        out_reg_commit_rob_index <= w_head_idx;
        out_reg_set_nzcv         <= r_set_nzcv[w_head_idx];
        out_reg_nzcv             <= r_nzcv[w_head_idx];
      end
      if (w_flush) begin
        out_fetch_new_PC <= r_new_pc[w_head_idx];
      end

      if (w_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_commit) begin
          r_head <= r_head + PTR_ONE;
        end
        if (w_alloc) begin
          r_tail <= r_tail + PTR_ONE;
        end
      end

      // Alloc, commit and completion never target the same entry in one edge:
      // the alloc slot is FREE, and the commit slot is DONE, so neither can
      // accept a completion.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_flush) begin
          r_state[i] <= ST_FREE;
        end else if (w_alloc && (w_tail_idx == IDX_W'(i))) begin
          r_state[i]    <= ST_WAIT;
          r_dst[i]      <= in_reg_dst;
          r_set_nzcv[i] <= in_reg_set_nzcv;
          r_mispred[i]  <= 1'b0;
        end else if (w_commit && (w_head_idx == IDX_W'(i))) begin
          r_state[i] <= ST_FREE;
        end else if (w_hit[i] && (r_state[i] == ST_WAIT)) begin
          r_state[i]   <= ST_DONE;
          r_value[i]   <= w_hit_value[i];
          r_nzcv[i]    <= w_hit_nzcv[i];
          r_mispred[i] <= w_hit_mispred[i];
          r_new_pc[i]  <= w_hit_pc[i];
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commits;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_perf_commits <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_commit) r_perf_commits <= r_perf_commits + 32'd1;
      if (w_flush)  r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign out_perf_commits = r_perf_commits;
  assign out_perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_rob_param.sv
// -----------------------------------------------------------------------------
// tb_rob_param -- directed self-checking bench for rob_param
// (DEPTH=16, DATA_W=64, REG_IDX_W=5, FU_PORTS=2)
// -----------------------------------------------------------------------------
module tb_rob_param;

  logic        clk;
  logic        rst;
  logic        reg_done;
  logic [4:0]  reg_dst;
  logic        reg_set_nzcv;
  logic [3:0]  next_idx;
  logic        full;
  logic [1:0]  fu_done;
  logic [7:0]  fu_idx;
  logic [127:0] fu_value;
  logic [7:0]  fu_nzcv;
  logic [1:0]  fu_misp;
  logic [127:0] fu_pc;
  logic [1:0]  bc_done;
  logic [7:0]  bc_idx;
  logic [127:0] bc_value;
  logic [7:0]  bc_nzcv;
  logic        c_done;
  logic [4:0]  c_reg;
  logic [63:0] c_value;
  logic [3:0]  c_rob;
  logic        c_set_nzcv;
  logic [3:0]  c_nzcv;
  logic        f_misp;
  logic [63:0] f_pc;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits;
  logic [31:0] perf_flushes;
`endif

  int total = 0;
  int bad   = 0;

  rob_param #(.DEPTH(16), .DATA_W(64), .REG_IDX_W(5), .FU_PORTS(2)) dut (
    .in_clk                   (clk),
    .in_rst                   (rst),
    .in_reg_done              (reg_done),
    .in_reg_dst               (reg_dst),
    .in_reg_set_nzcv          (reg_set_nzcv),
    .out_reg_next_rob_index   (next_idx),
    .out_reg_full             (full),
    .in_fu_done               (fu_done),
    .in_fu_dst_rob_index      (fu_idx),
    .in_fu_value              (fu_value),
    .in_fu_nzcv               (fu_nzcv),
    .in_fu_is_mispred         (fu_misp),
    .in_fu_new_PC             (fu_pc),
    .out_rs_broadcast_done    (bc_done),
    .out_rs_broadcast_index   (bc_idx),
    .out_rs_broadcast_value   (bc_value),
    .out_rs_broadcast_nzcv    (bc_nzcv),
    .out_reg_commit_done      (c_done),
    .out_reg_index            (c_reg),
    .out_reg_commit_value     (c_value),
    .out_reg_commit_rob_index (c_rob),
    .out_reg_set_nzcv         (c_set_nzcv),
    .out_reg_nzcv             (c_nzcv),
    .out_fetch_mispredict     (f_misp),
    .out_fetch_new_PC         (f_pc)
`ifdef ROB_PERF_CNT_EN
    ,
    .out_perf_commits         (perf_commits),
    .out_perf_flushes         (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reg_done     = 1'b0;
    reg_dst      = '0;
    reg_set_nzcv = 1'b0;
    fu_done      = '0;
    fu_idx       = '0;
    fu_value     = '0;
    fu_nzcv      = '0;
    fu_misp      = '0;
    fu_pc        = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] dst, input logic snz);
    reg_done     = 1'b1;
    reg_dst      = dst;
    reg_set_nzcv = snz;
  endtask

  task automatic fu(input int p, input logic [3:0] idx, input logic [63:0] val,
                    input logic [3:0] nz, input logic misp, input logic [63:0] pc);
    fu_done[p]          = 1'b1;
    fu_idx[p*4 +: 4]    = idx;
    fu_value[p*64 +: 64] = val;
    fu_nzcv[p*4 +: 4]   = nz;
    fu_misp[p]          = misp;
    fu_pc[p*64 +: 64]   = pc;
  endtask

  // Reset overrides same-edge allocation and completion
  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    alloc(5'd7, 1'b0);
    fu(0, 4'd0, 64'h1234, 4'h0, 1'b0, 64'h0);
    step();
    rst = 1'b0;
    clear_in();
    total++; if (full !== 1'b0) begin $display("FAIL reset_full got=%0h exp=0", full); bad++; end
    total++; if (next_idx !== 4'd0) begin $display("FAIL reset_next got=%0h exp=0", next_idx); bad++; end
    total++; if (bc_done !== 2'b00) begin $display("FAIL reset_bc got=%0h exp=0", bc_done); bad++; end
    total++; if (c_done !== 1'b0) begin $display("FAIL reset_commit got=%0h exp=0", c_done); bad++; end
    total++; if (f_misp !== 1'b0 || f_pc !== 64'h0) begin
      $display("FAIL reset_fetch got=%0h/%0h exp=0/0", f_misp, f_pc); bad++; end
    $display("test_reset: done");
  endtask

  // Allocate dst=3, complete idx 0 with 0x2A, observe broadcast then commit
  task automatic test_basic();
    do_reset();
    alloc(5'd3, 1'b1);
    step();
    clear_in();
    total++; if (next_idx !== 4'd1) begin $display("FAIL basic_next got=%0h exp=1", next_idx); bad++; end
    fu(0, 4'd0, 64'h2A, 4'hA, 1'b0, 64'h0);
    step();
    clear_in();
    total++; if (bc_done !== 2'b01 || bc_idx[3:0] !== 4'd0 || bc_value[63:0] !== 64'h2A || bc_nzcv[3:0] !== 4'hA) begin
      $display("FAIL basic_bcast got=%0h/%0h/%0h/%0h exp=1/0/2a/a", bc_done, bc_idx[3:0], bc_value[63:0], bc_nzcv[3:0]); bad++; end
    total++; if (c_done !== 1'b0) begin $display("FAIL basic_early_commit got=%0h exp=0", c_done); bad++; end
    step();
    total++; if (c_done !== 1'b1 || c_reg !== 5'd3 || c_value !== 64'h2A || c_rob !== 4'd0) begin
      $display("FAIL basic_commit got=%0h/%0h/%0h/%0h exp=1/3/2a/0", c_done, c_reg, c_value, c_rob); bad++; end
    total++; if (c_set_nzcv !== 1'b1 || c_nzcv !== 4'hA) begin
      $display("FAIL basic_nzcv got=%0h/%0h exp=1/a", c_set_nzcv, c_nzcv); bad++; end
    total++; if (bc_done !== 2'b00) begin $display("FAIL basic_bc_pulse got=%0h exp=0", bc_done); bad++; end
    step();
    total++; if (c_done !== 1'b0) begin $display("FAIL basic_commit_pulse got=%0h exp=0", c_done); bad++; end
    $display("test_basic: done");
  endtask

  // 16 allocations fill the buffer, the 17th is dropped
  task automatic test_full();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      alloc(5'(k), 1'b0);
      step();
    end
    total++; if (full !== 1'b0 || next_idx !== 4'd15) begin
      $display("FAIL full_15 got=%0h/%0h exp=0/f", full, next_idx); bad++; end
    step();
    total++; if (full !== 1'b1 || next_idx !== 4'd0) begin
      $display("FAIL full_16 got=%0h/%0h exp=1/0", full, next_idx); bad++; end
    step();
    clear_in();
    total++; if (full !== 1'b1 || next_idx !== 4'd0) begin
      $display("FAIL full_17 got=%0h/%0h exp=1/0", full, next_idx); bad++; end
    step();
    total++; if (c_done !== 1'b0) begin $display("FAIL full_no_commit got=%0h exp=0", c_done); bad++; end
    $display("test_full: done");
  endtask

  // Out-of-order completion retires in order
  task automatic test_order();
    do_reset();
    alloc(5'd7, 1'b0);
    step();
    alloc(5'd8, 1'b0);
    step();
    clear_in();
    fu(0, 4'd1, 64'h11, 4'h0, 1'b0, 64'h0);
    fu(1, 4'd5, 64'h99, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    total++; if (bc_done !== 2'b11 || bc_idx !== 8'h51) begin
      $display("FAIL order_bcast got=%0h/%0h exp=3/51", bc_done, bc_idx); bad++; end
    total++; if (c_done !== 1'b0) begin $display("FAIL order_wait got=%0h exp=0", c_done); bad++; end
    fu(0, 4'd0, 64'h22, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    total++; if (c_done !== 1'b0) begin $display("FAIL order_wait2 got=%0h exp=0", c_done); bad++; end
    step();
    total++; if (c_done !== 1'b1 || c_rob !== 4'd0 || c_value !== 64'h22 || c_reg !== 5'd7) begin
      $display("FAIL order_first got=%0h/%0h/%0h/%0h exp=1/0/22/7", c_done, c_rob, c_value, c_reg); bad++; end
    step();
    total++; if (c_done !== 1'b1 || c_rob !== 4'd1 || c_value !== 64'h11 || c_reg !== 5'd8) begin
      $display("FAIL order_second got=%0h/%0h/%0h/%0h exp=1/1/11/8", c_done, c_rob, c_value, c_reg); bad++; end
    step();
    total++; if (c_done !== 1'b0) begin $display("FAIL order_idle got=%0h exp=0", c_done); bad++; end
    $display("test_order: done");
  endtask

  // Both ports name index 2 in one cycle: port 0 wins
  task automatic test_same_index();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc(5'(10 + k), 1'b0);
      step();
    end
    clear_in();
    fu(0, 4'd0, 64'h1, 4'h0, 1'b0, 64'h0);
    fu(1, 4'd1, 64'h2, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    fu(0, 4'd2, 64'h5, 4'h0, 1'b0, 64'h0);
    fu(1, 4'd2, 64'h9, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    total++; if (bc_done !== 2'b11 || bc_value[63:0] !== 64'h5 || bc_value[127:64] !== 64'h9) begin
      $display("FAIL same_bcast got=%0h/%0h/%0h exp=3/5/9", bc_done, bc_value[63:0], bc_value[127:64]); bad++; end
    step();
    step();
    total++; if (c_done !== 1'b1 || c_rob !== 4'd2 || c_value !== 64'h5 || c_reg !== 5'd12) begin
      $display("FAIL same_commit got=%0h/%0h/%0h/%0h exp=1/2/5/c", c_done, c_rob, c_value, c_reg); bad++; end
    $display("test_same_index: done");
  endtask

  // Entry 1 mispredicts: flush, redirect to 0x400, entry 2 never retires
  task automatic test_mispred();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc(5'(1 + k), 1'b0);
      step();
    end
    clear_in();
    fu(0, 4'd0, 64'hA, 4'h0, 1'b0, 64'h0);
    fu(1, 4'd1, 64'hB, 4'h0, 1'b1, 64'h400);
    step();
    clear_in();
    fu(0, 4'd2, 64'hC, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    total++; if (c_done !== 1'b1 || c_rob !== 4'd0 || f_misp !== 1'b0) begin
      $display("FAIL misp_first got=%0h/%0h/%0h exp=1/0/0", c_done, c_rob, f_misp); bad++; end
    alloc(5'd9, 1'b0);
    step();
    clear_in();
    total++; if (c_done !== 1'b1 || c_rob !== 4'd1 || c_value !== 64'hB) begin
      $display("FAIL misp_commit got=%0h/%0h/%0h exp=1/1/b", c_done, c_rob, c_value); bad++; end
    total++; if (f_misp !== 1'b1 || f_pc !== 64'h400) begin
      $display("FAIL misp_flush got=%0h/%0h exp=1/400", f_misp, f_pc); bad++; end
    total++; if (next_idx !== 4'd0 || full !== 1'b0) begin
      $display("FAIL misp_ptrs got=%0h/%0h exp=0/0", next_idx, full); bad++; end
    step();
    total++; if (c_done !== 1'b0 || f_misp !== 1'b0) begin
      $display("FAIL misp_pulse got=%0h/%0h exp=0/0", c_done, f_misp); bad++; end
    step();
    total++; if (c_done !== 1'b0) begin $display("FAIL misp_entry2 got=%0h exp=0", c_done); bad++; end
`ifdef ROB_PERF_CNT_EN
    total++; if (perf_commits !== 32'd2 || perf_flushes !== 32'd1) begin
      $display("FAIL misp_perf got=%0d/%0d exp=2/1", perf_commits, perf_flushes); bad++; end
`endif
    alloc(5'd4, 1'b0);
    step();
    clear_in();
    total++; if (next_idx !== 4'd1) begin $display("FAIL misp_realloc got=%0h exp=1", next_idx); bad++; end
    $display("test_mispred: done");
  endtask

  // Reset in flight discards a DONE entry with no pulses afterwards
  task automatic test_reset_mid();
    do_reset();
    alloc(5'd4, 1'b0);
    step();
    clear_in();
    fu(0, 4'd0, 64'h55, 4'h0, 1'b0, 64'h0);
    step();
    clear_in();
    rst = 1'b1;
    fu(1, 4'd0, 64'h66, 4'h0, 1'b0, 64'h0);
    step();
    rst = 1'b0;
    clear_in();
    total++; if (c_done !== 1'b0 || bc_done !== 2'b00 || next_idx !== 4'd0) begin
      $display("FAIL rstmid_out got=%0h/%0h/%0h exp=0/0/0", c_done, bc_done, next_idx); bad++; end
    step();
    total++; if (c_done !== 1'b0) begin $display("FAIL rstmid_late got=%0h exp=0", c_done); bad++; end
    $display("test_reset_mid: done");
  endtask

  // 40 pipelined alloc/complete/commit cycles, pointers wrap twice
  task automatic test_wrap();
    logic [3:0]  exp_rob;
    logic [3:0]  exp_next;
    logic [63:0] exp_val;
    logic [4:0]  exp_reg;
    logic        exp_done;
    do_reset();
    for (int i = 0; i < 42; i++) begin
      clear_in();
      if (i < 40) alloc(5'(i % 32), 1'b0);
      if (i >= 1 && i <= 40) fu(0, 4'((i - 1) % 16), 64'(256 + i - 1), 4'h0, 1'b0, 64'h0);
      step();
      exp_done = (i >= 2);
      exp_rob  = 4'((i - 2) % 16);
      exp_val  = 64'(256 + i - 2);
      exp_reg  = 5'((i - 2) % 32);
      exp_next = (i < 40) ? 4'((i + 1) % 16) : 4'd8;
      total++; if (c_done !== exp_done) begin
        $display("FAIL wrap_done[%0d] got=%0h exp=%0h", i, c_done, exp_done); bad++; end
      if (exp_done) begin
        total++; if (c_rob !== exp_rob || c_value !== exp_val || c_reg !== exp_reg) begin
          $display("FAIL wrap_commit[%0d] got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, c_rob, c_value, c_reg,
                   exp_rob, exp_val, exp_reg); bad++; end
      end
      total++; if (next_idx !== exp_next) begin
        $display("FAIL wrap_next[%0d] got=%0h exp=%0h", i, next_idx, exp_next); bad++; end
    end
    clear_in();
`ifdef ROB_PERF_CNT_EN
    total++; if (perf_commits !== 32'd40 || perf_flushes !== 32'd0) begin
      $display("FAIL wrap_perf got=%0d/%0d exp=40/0", perf_commits, perf_flushes); bad++; end
`endif
    $display("test_wrap: done");
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    step();
    test_reset();
    test_basic();
    test_full();
    test_order();
    test_same_index();
    test_mispred();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
